mem_access_unit: RTL

- Sequences the data-memory port for load/store ALU codes (ALU_LB..ALU_SW) issued from EX.
- Accepts one request at a time over a valid/ready handshake, drives a req/ack memory bus with byte enables, and formats load data (lane select plus sign/zero extension).
- Returns a write-back packet to the register file path, flags misaligned accesses, and flags memory timeouts.
- Sits between the EX stage and the data-memory interface; the pipeline stalls while reqReady is low.

---
 rtl/mem_access_unit_pkg.sv | 54 +++++
 rtl/mem_access_unit_decoder.sv | 25 ++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared ALU codes, memory access types and lane helpers
package mem_access_unit_pkg;

  // Non-memory codes, enough to exercise the discard path
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;

  // Memory codes, contiguous from ALU_LB to ALU_SW
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  typedef enum logic [1:0] {
    MEM_BYTE,
    MEM_HALF,
    MEM_WORD
  } mem_access_size_e;

  typedef struct packed {
    logic             is_load;
    logic             is_store;
    mem_access_size_e size;
    logic             is_unsigned;
  } mem_access_ctrl_t;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_access_state_e;

  // Byte lanes touched by an access; loads and stores share the pattern
  function automatic logic [3:0] byte_enables(input mem_access_size_e size, input logic [1:0] ofs);
    case (size)
      MEM_BYTE: byte_enables = 4'b0001 << ofs;
      MEM_HALF: byte_enables = ofs[1] ? 4'b1100 : 4'b0011;
      default:  byte_enables = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every lane carries it regardless of offset
  function automatic logic [31:0] store_lanes(input mem_access_size_e size, input logic [31:0] data);
    case (size)
      MEM_BYTE: store_lanes = {4{data[7:0]}};
      MEM_HALF: store_lanes = {2{data[15:0]}};
      default:  store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_decoder.sv
// rtl/mem_access_unit_decoder.sv - ALU code to memory access control decode
module mem_access_decoder
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]       aluCode,
  output mem_access_ctrl_t ctrl
);

  // Non-memory codes leave both is_load and is_store clear
  always_comb begin
    ctrl = '0;
    case (aluCode)
      ALU_LB:  begin ctrl.is_load  = 1'b1; ctrl.size = MEM_BYTE; end
      ALU_LH:  begin ctrl.is_load  = 1'b1; ctrl.size = MEM_HALF; end
      ALU_LW:  begin ctrl.is_load  = 1'b1; ctrl.size = MEM_WORD; end
      ALU_LBU: begin ctrl.is_load  = 1'b1; ctrl.size = MEM_BYTE; ctrl.is_unsigned = 1'b1; end
      ALU_LHU: begin ctrl.is_load  = 1'b1; ctrl.size = MEM_HALF; ctrl.is_unsigned = 1'b1; end
      ALU_SB:  begin ctrl.is_store = 1'b1; ctrl.size = MEM_BYTE; end
      ALU_SH:  begin ctrl.is_store = 1'b1; ctrl.size = MEM_HALF; end
      ALU_SW:  begin ctrl.is_store = 1'b1; ctrl.size = MEM_WORD; end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer between EX and the data-memory port
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [5:0]  aluCode,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  input  logic [4:0]  rd,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        wbValid,
  output logic [4:0]  wbRd,
  output logic [31:0] wbData,
  output logic        misaligned,
  output logic        memTimeout
);

  localparam int             CW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  LIMIT      = CW'(TIMEOUT_CYCLES - 1);
  localparam logic           TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  mem_access_state_e state, state_next;
  mem_access_ctrl_t  ctrl;
  logic              is_misaligned, start, fault, done, abort;
  logic [CW-1:0]     cnt;
  logic              load_q, unsigned_q;
  mem_access_size_e  size_q;
  logic [1:0]        ofs_q;
  logic [4:0]        rd_q;
  logic [31:0]       load_data;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;

  mem_access_decoder u_decoder (
    .aluCode (aluCode),
    .ctrl    (ctrl)
  );

  assign is_misaligned = (ctrl.size == MEM_HALF && addr[0]) ||
                         (ctrl.size == MEM_WORD && addr[1:0] != 2'b00);
  assign reqReady      = (state == MEM_IDLE);
  assign memReq        = (state == MEM_WAIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_next;
  end

  // Next state: accept/decode in IDLE, completion or timeout abort in WAIT (ack beats timeout)
  always_comb begin
    state_next = state;
    start      = 1'b0;
    fault      = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (reqValid && (ctrl.is_load || ctrl.is_store)) begin
          if (is_misaligned) begin
            fault = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (memAck) begin
          done       = 1'b1;
          state_next = MEM_IDLE;
        end else if (TIMEOUT_EN && cnt == LIMIT) begin
          abort      = 1'b1;
          state_next = MEM_IDLE;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // Wait-cycle counter, zero on the first WAIT cycle of every access
  always_ff @(posedge clk) begin
    if (rst || state != MEM_WAIT || memAck) cnt <= '0;
    else                                    cnt <= cnt + 1'b1;
  end

  // Select and extend the addressed lane of the returned word
  always_comb begin
    lane_byte = memRdata[{ofs_q, 3'b000} +: 8];
    lane_half = ofs_q[1] ? memRdata[31:16] : memRdata[15:0];
    case (size_q)
      MEM_BYTE: load_data = unsigned_q ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      MEM_HALF: load_data = unsigned_q ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default:  load_data = memRdata;
    endcase
  end

  // Bus registers captured at accept, write-back and flag pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      memBe      <= '0;
      wbValid    <= 1'b0;
      wbRd       <= '0;
      wbData     <= '0;
      misaligned <= 1'b0;
      memTimeout <= 1'b0;
      load_q     <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= MEM_WORD;
      ofs_q      <= '0;
      rd_q       <= '0;
    end else begin
      wbValid    <= done && load_q;
      misaligned <= fault;
      memTimeout <= abort;
      if (start) begin
        memWe      <= ctrl.is_store;
        memAddr    <= {addr[31:2], 2'b00};
        memWdata   <= store_lanes(ctrl.size, storeData);
        memBe      <= byte_enables(ctrl.size, addr[1:0]);
        load_q     <= ctrl.is_load;
        unsigned_q <= ctrl.is_unsigned;
        size_q     <= ctrl.size;
        ofs_q      <= addr[1:0];
        rd_q       <= rd;
      end
      if (done && load_q) begin
        wbRd   <= rd_q;
        wbData <= load_data;
      end
    end
  end

endmodule
